// File: rtl/delay_calc_pkg.sv
// rtl/delay_calc_pkg.sv - shared widths, sequencer states and operand bundle for the delay calculator
// Contents:
//   NW/AW/ASQW/EW/CW  field widths derived from the integer/fractional splits
//   seq_state_t       sequencer state encoding
//   calc_operands_t   operand registers presented to the calculator
//   idx_width()       element index width (never below 1 bit)
package delay_calc_pkg;

  localparam int N_DW_INTEGER        = 13;
  localparam int A_DW_INTEGER        = 3;
  localparam int ERROR_DW_INTEGER    = 14;
  localparam int INC_TERM_DW_INTEGER = 16;
  localparam int DW_FRACTIONAL       = 2;

  localparam int NW   = N_DW_INTEGER + DW_FRACTIONAL + 1;
  localparam int AW   = A_DW_INTEGER + DW_FRACTIONAL + 1;
  localparam int ASQW = 2 * A_DW_INTEGER + DW_FRACTIONAL + 1;
  localparam int EW   = ERROR_DW_INTEGER + DW_FRACTIONAL + 1;
  localparam int CW   = INC_TERM_DW_INTEGER + DW_FRACTIONAL + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic        [NW-1:0]   n_prev;
    logic signed [AW-1:0]   a_prev;
    logic        [ASQW-1:0] a_prev_sq;
    logic signed [CW-1:0]   comp_term;
    logic signed [CW-1:0]   comp_term_prev;
    logic signed [EW-1:0]   error_prev;
  } calc_operands_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - saturating cycle counter guarding the calculator response
// Ports:
//   clk, rst    clock, async active-high reset
//   i_clear     restart the count at zero
//   i_enable    count one cycle
//   o_expired   count has reached TIMEOUT_CYCLES-1
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CNTW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT_CYCLES - 1);

  logic [CNTW-1:0] r_count;

  // Saturates at LIMIT so o_expired stays asserted until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + CNTW'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/delay_chain_sequencer.sv
// rtl/delay_chain_sequencer.sv - per-element initiator of the incremental delay calculator
// Ports:
//   clk, rst                         clock, async active-high reset
//   i_start, i_n_seed                scanline start pulse and starting delay
//   o_busy, o_done, o_timeout_err    scanline status (timeout_err sticky until next start)
//   i_ct_valid/o_ct_ready/i_ct_data  comparator-term input stream
//   o_calc_initiate, o_calc_*_prev,
//   o_calc_comp_term                 calculator request and held operands
//   i_calc_*_next, i_calc_ready      calculator results
//   o_dly_valid/i_dly_ready,
//   o_dly_data/o_dly_index/o_dly_last delay output stream
module delay_chain_sequencer
  import delay_calc_pkg::*;
#(
  parameter int  NUM_ELEMENTS   = 64,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int IW             = idx_width(NUM_ELEMENTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic        [NW-1:0]   i_n_seed,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout_err,
  input  logic                   i_ct_valid,
  output logic                   o_ct_ready,
  input  logic signed [CW-1:0]   i_ct_data,
  output logic                   o_calc_initiate,
  output logic        [NW-1:0]   o_calc_n_prev,
  output logic signed [AW-1:0]   o_calc_a_prev,
  output logic        [ASQW-1:0] o_calc_a_prev_sq,
  output logic signed [CW-1:0]   o_calc_comp_term,
  output logic signed [CW-1:0]   o_calc_comp_term_prev,
  output logic signed [EW-1:0]   o_calc_error_prev,
  input  logic        [NW-1:0]   i_calc_n_next,
  input  logic signed [AW-1:0]   i_calc_a_next,
  input  logic        [ASQW-1:0] i_calc_a_next_sq,
  input  logic signed [CW-1:0]   i_calc_comp_term_next,
  input  logic signed [EW-1:0]   i_calc_error_next,
  input  logic                   i_calc_ready,
  output logic                   o_dly_valid,
  input  logic                   i_dly_ready,
  output logic        [NW-1:0]   o_dly_data,
  output logic        [IW-1:0]   o_dly_index,
  output logic                   o_dly_last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEMENTS - 1);

  seq_state_t     r_state;
  calc_operands_t r_ops;
  logic [IW-1:0]  r_index;
  logic           r_first;
  logic           r_busy;
  logic           r_done;
  logic           r_timeout_err;
  logic           r_calc_initiate;
  logic           r_dly_valid;
  logic [NW-1:0]  r_dly_data;
  logic [IW-1:0]  r_dly_index;
  logic           r_dly_last;

  seq_state_t     w_state_next;
  calc_operands_t w_ops_next;
  logic [IW-1:0]  w_index_next;
  logic           w_first_next;
  logic           w_busy_next;
  logic           w_done_next;
  logic           w_timeout_err_next;
  logic           w_calc_initiate_next;
  logic           w_dly_valid_next;
  logic [NW-1:0]  w_dly_data_next;
  logic [IW-1:0]  w_dly_index_next;
  logic           w_dly_last_next;

  logic           w_wd_clear;
  logic           w_wd_enable;
  logic           w_wd_expired;

  // The count restarts while the request is issued, so the first WAIT cycle sees zero.
  assign w_wd_clear  = (r_state == ISSUE);
  assign w_wd_enable = (r_state == WAIT);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_ops           <= '0;
      r_index         <= '0;
      r_first         <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_calc_initiate <= 1'b0;
      r_dly_valid     <= 1'b0;
      r_dly_data      <= '0;
      r_dly_index     <= '0;
      r_dly_last      <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_ops           <= w_ops_next;
      r_index         <= w_index_next;
      r_first         <= w_first_next;
      r_busy          <= w_busy_next;
      r_done          <= w_done_next;
      r_timeout_err   <= w_timeout_err_next;
      r_calc_initiate <= w_calc_initiate_next;
      r_dly_valid     <= w_dly_valid_next;
      r_dly_data      <= w_dly_data_next;
      r_dly_index     <= w_dly_index_next;
      r_dly_last      <= w_dly_last_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_ops_next           = r_ops;
    w_index_next         = r_index;
    w_first_next         = r_first;
    w_busy_next          = r_busy;
    w_done_next          = 1'b0;
    w_timeout_err_next   = r_timeout_err;
    w_calc_initiate_next = 1'b0;
    w_dly_valid_next     = r_dly_valid;
    w_dly_data_next      = r_dly_data;
    w_dly_index_next     = r_dly_index;
    w_dly_last_next      = r_dly_last;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next          = FETCH;
          w_ops_next.n_prev     = i_n_seed;
          w_ops_next.a_prev     = '0;
          w_ops_next.a_prev_sq  = '0;
          w_ops_next.error_prev = '0;
          w_index_next          = '0;
          w_first_next          = 1'b1;
          w_timeout_err_next    = 1'b0;
          w_busy_next           = 1'b1;
        end
      end

      FETCH: begin
        // ct_ready is decoded from FETCH, so ct_valid alone completes the handshake.
        if (i_ct_valid) begin
          w_ops_next.comp_term = i_ct_data;
          // The first element has no predecessor; it is its own previous term.
          if (r_first) begin
            w_ops_next.comp_term_prev = i_ct_data;
          end
          w_state_next         = ISSUE;
          w_calc_initiate_next = !i_calc_ready;
        end
      end

      ISSUE: begin
        // Initiate is registered: it is high this cycle only if calc_ready was low
        // last cycle, otherwise keep waiting for the calculator to drop its old result.
        if (r_calc_initiate) begin
          w_state_next = WAIT;
        end else begin
          w_calc_initiate_next = !i_calc_ready;
        end
      end

      WAIT: begin
        if (i_calc_ready) begin
          w_ops_next.n_prev         = i_calc_n_next;
          w_ops_next.a_prev         = i_calc_a_next;
          w_ops_next.a_prev_sq      = i_calc_a_next_sq;
          w_ops_next.error_prev     = i_calc_error_next;
          w_ops_next.comp_term_prev = i_calc_comp_term_next;
          w_first_next              = 1'b0;
          w_state_next              = EMIT;
          w_dly_valid_next          = 1'b1;
          w_dly_data_next           = i_calc_n_next;
          w_dly_index_next          = r_index;
          w_dly_last_next           = (r_index == LAST_IDX);
        end else if (w_wd_expired) begin
          w_timeout_err_next = 1'b1;
          w_state_next       = DONE;
          w_done_next        = 1'b1;
        end
      end

      EMIT: begin
        if (i_dly_ready) begin
          w_dly_valid_next = 1'b0;
          if (r_dly_last) begin
            w_state_next = DONE;
            w_done_next  = 1'b1;
          end else begin
            w_index_next = r_index + IW'(1);
            w_state_next = FETCH;
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_ct_ready            = (r_state == FETCH);
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_timeout_err         = r_timeout_err;
  assign o_calc_initiate       = r_calc_initiate;
  assign o_calc_n_prev         = r_ops.n_prev;
  assign o_calc_a_prev         = r_ops.a_prev;
  assign o_calc_a_prev_sq      = r_ops.a_prev_sq;
  assign o_calc_comp_term      = r_ops.comp_term;
  assign o_calc_comp_term_prev = r_ops.comp_term_prev;
  assign o_calc_error_prev     = r_ops.error_prev;
  assign o_dly_valid           = r_dly_valid;
  assign o_dly_data            = r_dly_data;
  assign o_dly_index           = r_dly_index;
  assign o_dly_last            = r_dly_last;

endmodule

// File: tb/tb_delay_chain_sequencer.sv
// tb/tb_delay_chain_sequencer.sv - self-checking bench for delay_chain_sequencer
module tb_delay_chain_sequencer;
  import delay_calc_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic        [NW-1:0]   n_seed;
  logic                   busy, done, timeout_err;
  logic                   ct_valid, ct_ready;
  logic signed [CW-1:0]   ct_data;
  logic                   calc_initiate;
  logic        [NW-1:0]   calc_n_prev;
  logic signed [AW-1:0]   calc_a_prev;
  logic        [ASQW-1:0] calc_a_prev_sq;
  logic signed [CW-1:0]   calc_comp_term, calc_comp_term_prev;
  logic signed [EW-1:0]   calc_error_prev;
  logic        [NW-1:0]   calc_n_next;
  logic signed [AW-1:0]   calc_a_next;
  logic        [ASQW-1:0] calc_a_next_sq;
  logic signed [CW-1:0]   calc_comp_term_next;
  logic signed [EW-1:0]   calc_error_next;
  logic                   calc_ready;
  logic                   dly_valid, dly_ready;
  logic        [NW-1:0]   dly_data;
  logic        [1:0]      dly_index;
  logic                   dly_last;

  int n_checks = 0;
  int n_fail   = 0;

  delay_chain_sequencer #(.NUM_ELEMENTS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_n_seed(n_seed),
    .o_busy(busy), .o_done(done), .o_timeout_err(timeout_err),
    .i_ct_valid(ct_valid), .o_ct_ready(ct_ready), .i_ct_data(ct_data),
    .o_calc_initiate(calc_initiate), .o_calc_n_prev(calc_n_prev),
    .o_calc_a_prev(calc_a_prev), .o_calc_a_prev_sq(calc_a_prev_sq),
    .o_calc_comp_term(calc_comp_term), .o_calc_comp_term_prev(calc_comp_term_prev),
    .o_calc_error_prev(calc_error_prev),
    .i_calc_n_next(calc_n_next), .i_calc_a_next(calc_a_next),
    .i_calc_a_next_sq(calc_a_next_sq), .i_calc_comp_term_next(calc_comp_term_next),
    .i_calc_error_next(calc_error_next), .i_calc_ready(calc_ready),
    .o_dly_valid(dly_valid), .i_dly_ready(dly_ready), .o_dly_data(dly_data),
    .o_dly_index(dly_index), .o_dly_last(dly_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator stub: latency 5, n_next = n_prev + 1.0, fixed a/error/comp_term results,
  // calc_ready held for stub_hold_cfg extra cycles; stub_mute suppresses the response.
  int          stub_cnt, stub_hold;
  int          stub_hold_cfg = 0;
  bit          stub_mute = 1'b0;
  logic [NW-1:0] stub_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_ready <= 1'b0; stub_cnt <= 0; stub_hold <= 0; stub_n <= '0;
      calc_n_next <= '0; calc_a_next <= '0; calc_a_next_sq <= '0;
      calc_comp_term_next <= '0; calc_error_next <= '0;
    end else if (calc_initiate) begin
      stub_n   <= calc_n_prev;
      stub_cnt <= 5;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 1) begin
      stub_cnt <= 0;
      if (!stub_mute) begin
        calc_ready          <= 1'b1;
        calc_n_next         <= stub_n + 16'd4;
        calc_a_next         <= -6'sd3;
        calc_a_next_sq      <= 9'd9;
        calc_comp_term_next <= 19'sd2000;
        calc_error_next     <= 17'sd13;
        stub_hold           <= stub_hold_cfg;
      end
    end else if (calc_ready) begin
      if (stub_hold > 0) stub_hold <= stub_hold - 1;
      else calc_ready <= 1'b0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " all outputs zero"},
          |{busy, done, timeout_err, ct_ready, calc_initiate, dly_valid, dly_last,
            dly_data, dly_index, calc_n_prev, calc_a_prev, calc_a_prev_sq,
            calc_comp_term, calc_comp_term_prev, calc_error_prev}, 0);
  endtask

  typedef struct {
    logic [NW-1:0]        seed;
    int                   ct_base;   // ct_data for element e is ct_base + 8*e
    int                   ct_gap;    // cycles ct_valid held low in each FETCH
    int                   dly_gap;   // cycles dly_ready held low in each EMIT
    int                   hold;      // extra cycles calc_ready stays high
    logic [0:3][NW-1:0]   exp_dly;   // expected dly_data per element
  } vec_t;

  vec_t vecs[5];

  task automatic run_scanline(input vec_t v, input string tag,
                              output int n_hs, output int n_init, output int first_init_cyc,
                              output int last_hs_cyc, output int done_cyc);
    int ct_idx, fetch_cnt, emit_cnt, stall_bad, e;
    logic [NW-1:0] hold_data;
    logic [1:0]    hold_idx;
    bit            in_stall;
    n_hs = 0; n_init = 0; first_init_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    ct_idx = 0; fetch_cnt = 0; emit_cnt = 0; stall_bad = 0; in_stall = 1'b0;
    hold_data = '0; hold_idx = '0;
    stub_hold_cfg = v.hold;
    n_seed = v.seed;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    check({tag, " timeout_err cleared by start"}, timeout_err, 0);
    for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
      if (done) done_cyc = cyc;
      if (calc_initiate) begin
        e = n_init;
        check({tag, " initiate only with calc_ready low"}, calc_ready, 0);
        if (n_init == 0) first_init_cyc = cyc;
        if (e < 4) begin
          check({tag, " comp_term"}, $signed(calc_comp_term), v.ct_base + 8 * e);
          if (e == 0) begin
            check({tag, " n_prev first"}, calc_n_prev, v.seed);
            check({tag, " comp_term_prev first"}, $signed(calc_comp_term_prev), v.ct_base);
            check({tag, " a_prev first"}, $signed(calc_a_prev), 0);
            check({tag, " a_prev_sq first"}, calc_a_prev_sq, 0);
            check({tag, " error_prev first"}, $signed(calc_error_prev), 0);
          end else begin
            check({tag, " n_prev"}, calc_n_prev, v.exp_dly[e-1]);
            check({tag, " comp_term_prev"}, $signed(calc_comp_term_prev), 2000);
            check({tag, " a_prev"}, $signed(calc_a_prev), -3);
            check({tag, " a_prev_sq"}, calc_a_prev_sq, 9);
            check({tag, " error_prev"}, $signed(calc_error_prev), 13);
          end
        end
        n_init++;
      end
      ct_valid  = ct_ready && (fetch_cnt >= v.ct_gap);
      ct_data   = CW'(v.ct_base + 8 * ct_idx);
      dly_ready = dly_valid && (emit_cnt >= v.dly_gap);
      if (dly_valid) begin
        if (in_stall && (dly_data !== hold_data || dly_index !== hold_idx)) stall_bad++;
        hold_data = dly_data;
        hold_idx  = dly_index;
        in_stall  = !dly_ready;
      end
      if (fetch_cnt > 0 && !ct_ready) stall_bad++;
      if (ct_valid) begin
        ct_idx++; fetch_cnt = 0;
      end else if (ct_ready) begin
        fetch_cnt++;
      end
      if (dly_ready) begin
        if (n_hs < 4) begin
          check({tag, " dly_data"}, dly_data, v.exp_dly[n_hs]);
          check({tag, " dly_index"}, dly_index, n_hs);
          check({tag, " dly_last"}, dly_last, (n_hs == 3) ? 1 : 0);
        end
        last_hs_cyc = cyc; n_hs++; emit_cnt = 0; in_stall = 1'b0;
      end else if (dly_valid) begin
        emit_cnt++;
      end
      @(posedge clk); #1;
    end
    ct_valid = 1'b0; dly_ready = 1'b0;
    check({tag, " stall stability"}, stall_bad, 0);
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    int n_hs, n_init, fic, lhc, dc;
    run_scanline(v, tag, n_hs, n_init, fic, lhc, dc);
    check({tag, " done seen"}, (dc >= 0) ? 1 : 0, 1);
    check({tag, " dly count"}, n_hs, 4);
    check({tag, " initiate count"}, n_init, 4);
    check({tag, " done one cycle after last handshake"}, dc - lhc, 1);
    check({tag, " busy low after done"}, busy, 0);
    check({tag, " done single pulse"}, done, 0);
    check({tag, " timeout_err clear"}, timeout_err, 0);
  endtask

  task automatic reset_mid(input bit in_emit, input string tag);
    int guard;
    n_seed = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ct_data = 19'sd5; dly_ready = 1'b0;
    guard = 0;
    while (!(in_emit ? dly_valid : calc_initiate) && guard < 60) begin
      ct_valid = ct_ready;
      @(posedge clk); #1;
      guard++;
    end
    ct_valid = 1'b0;
    check({tag, " reached target state"}, (guard < 60) ? 1 : 0, 1);
    @(posedge clk); #1;
    check({tag, " busy before rst"}, busy, 1);
    #3 rst = 1'b1;
    #1;
    check_outputs_zero({tag, " async rst"});
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_outputs_zero({tag, " after rst release"});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_hs, n_init, fic, lhc, dc;
    vecs[0] = '{seed: 16'd400,   ct_base: 40,   ct_gap: 0, dly_gap: 0, hold: 0,
                exp_dly: {16'd404, 16'd408, 16'd412, 16'd416}};
    vecs[1] = '{seed: 16'd0,     ct_base: -100, ct_gap: 0, dly_gap: 0, hold: 0,
                exp_dly: {16'd4, 16'd8, 16'd12, 16'd16}};
    vecs[2] = '{seed: 16'd65520, ct_base: 300,  ct_gap: 0, dly_gap: 0, hold: 0,
                exp_dly: {16'd65524, 16'd65528, 16'd65532, 16'd0}};
    vecs[3] = '{seed: 16'd1000,  ct_base: 12,   ct_gap: 5, dly_gap: 7, hold: 0,
                exp_dly: {16'd1004, 16'd1008, 16'd1012, 16'd1016}};
    vecs[4] = '{seed: 16'd7,     ct_base: -8,   ct_gap: 0, dly_gap: 0, hold: 3,
                exp_dly: {16'd11, 16'd15, 16'd19, 16'd23}};

    rst = 1'b1; start = 1'b0; n_seed = '0; ct_valid = 1'b0; ct_data = '0; dly_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("idle after reset");

    for (int k = 0; k < 5; k++) begin
      run_and_check(vecs[k], $sformatf("vec%0d", k));
      repeat (2) @(posedge clk);
      #1;
    end

    stub_mute = 1'b1;
    run_scanline(vecs[0], "wdog", n_hs, n_init, fic, lhc, dc);
    check("wdog done seen", (dc >= 0) ? 1 : 0, 1);
    check("wdog no dly_valid", n_hs, 0);
    check("wdog single initiate", n_init, 1);
    check("wdog done after 8 wait cycles", dc - fic, 9);
    check("wdog timeout_err sticky", timeout_err, 1);
    check("wdog busy low", busy, 0);
    stub_mute = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("wdog timeout_err still set in idle", timeout_err, 1);
    run_and_check(vecs[0], "after wdog");

    reset_mid(1'b0, "rst in WAIT");
    run_and_check(vecs[0], "after rst WAIT");
    reset_mid(1'b1, "rst in EMIT");
    run_and_check(vecs[1], "after rst EMIT");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
